// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the seven-segment scan reader.
// Segment patterns are active-high with bit0=a .. bit6=g.
package sevenseg_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CODE_W = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    localparam logic [CODE_W-1:0] CODE_BLANK = 4'hE;
    localparam logic [CODE_W-1:0] CODE_ERR   = 4'hF;

    typedef enum logic {
        COLLECT   = 1'b0,
        FULL_PEND = 1'b1
    } state_e;

endpackage

// File: rtl/sevenseg_to_bcd.sv
// Combinational pattern decoder: seven segment lines to a BCD code,
// with blank mapped to CODE_BLANK and anything unrecognised flagged.
module sevenseg_to_bcd
    import sevenseg_pkg::*;
(
    input  logic [SEG_W-1:0]  seg_i,
    output logic [CODE_W-1:0] code_o,
    output logic              err_o
);

    always_comb begin
        code_o = CODE_ERR;
        err_o  = 1'b1;
        case (seg_i)
            SEG_0:     begin code_o = 4'd0;       err_o = 1'b0; end
            SEG_1:     begin code_o = 4'd1;       err_o = 1'b0; end
            SEG_2:     begin code_o = 4'd2;       err_o = 1'b0; end
            SEG_3:     begin code_o = 4'd3;       err_o = 1'b0; end
            SEG_4:     begin code_o = 4'd4;       err_o = 1'b0; end
            SEG_5:     begin code_o = 4'd5;       err_o = 1'b0; end
            SEG_6:     begin code_o = 4'd6;       err_o = 1'b0; end
            SEG_7:     begin code_o = 4'd7;       err_o = 1'b0; end
            SEG_8:     begin code_o = 4'd8;       err_o = 1'b0; end
            SEG_9:     begin code_o = 4'd9;       err_o = 1'b0; end
            SEG_BLANK: begin code_o = CODE_BLANK; err_o = 1'b0; end
            default:   begin code_o = CODE_ERR;   err_o = 1'b1; end
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_reader.sv
// Recovers BCD digits from a multiplexed 7-segment bus: debounces each digit
// dwell, assembles a frame of NDIG digits and offers it on valid/ready.
module sevenseg_scan_reader
    import sevenseg_pkg::*;
#(
    parameter int unsigned NDIG   = 4,
    parameter int unsigned STABLE = 4,
    parameter int unsigned CW     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               seg,
    input  logic [NDIG-1:0]          an,
    output logic [CODE_W*NDIG-1:0]   digits,
    output logic [NDIG-1:0]          dps,
    output logic [NDIG-1:0]          err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overrun
);

    logic [7:0]                   seg_q;
    logic [NDIG-1:0]              an_q;
    logic [CW-1:0]                run_q, run_d;
    logic [NDIG-1:0][CODE_W-1:0]  buf_code_q, buf_code_d;
    logic [NDIG-1:0]              buf_dp_q, buf_dp_d;
    logic [NDIG-1:0]              buf_err_q, buf_err_d;
    logic [NDIG-1:0]              mask_q, mask_d;
    state_e                       state_q;

    logic [CODE_W-1:0]            dec_code;
    logic                         dec_err;
    logic                         valid_sel, same, capture, frame_done, handshake;

    sevenseg_to_bcd u_dec (
        .seg_i  (seg[SEG_W-1:0]),
        .code_o (dec_code),
        .err_o  (dec_err)
    );

    // Run tracker and capture into the frame buffer
    always_comb begin
        valid_sel  = (an != '0) && ((an & (an - NDIG'(1))) == '0);
        same       = valid_sel && (seg == seg_q) && (an == an_q);
        run_d      = valid_sel ? CW'(1) : '0;
        if (same) begin
            run_d = (run_q == CW'(STABLE)) ? run_q : run_q + CW'(1);
        end
        capture    = same && (run_q == CW'(STABLE - 1));
        buf_code_d = buf_code_q;
        buf_dp_d   = buf_dp_q;
        buf_err_d  = buf_err_q;
        mask_d     = mask_q;
        if (capture) begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                if (an[i]) begin
                    buf_code_d[i] = dec_code;
                    buf_dp_d[i]   = seg[7];
                    buf_err_d[i]  = dec_err;
                    mask_d[i]     = 1'b1;
                end
            end
        end
        frame_done = capture && (mask_d == '1);
        handshake  = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= '0;
            an_q       <= '0;
            run_q      <= '0;
            buf_code_q <= '0;
            buf_dp_q   <= '0;
            buf_err_q  <= '0;
            mask_q     <= '0;
            state_q    <= COLLECT;
            digits     <= '0;
            dps        <= '0;
            err        <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            seg_q      <= seg;
            an_q       <= an;
            run_q      <= run_d;
            buf_code_q <= buf_code_d;
            buf_dp_q   <= buf_dp_d;
            buf_err_q  <= buf_err_d;
            mask_q     <= frame_done ? '0 : mask_d;
            case (state_q)
                COLLECT: begin
                    if (frame_done) begin
                        digits    <= buf_code_d;
                        dps       <= buf_dp_d;
                        err       <= buf_err_d;
                        out_valid <= 1'b1;
                        state_q   <= FULL_PEND;
                    end
                end
                FULL_PEND: begin
                    // A completed frame replaces the accepted one, or is dropped
                    if (frame_done && handshake) begin
                        digits <= buf_code_d;
                        dps    <= buf_dp_d;
                        err    <= buf_err_d;
                    end else if (frame_done) begin
                        overrun <= 1'b1;
                    end else if (handshake) begin
                        out_valid <= 1'b0;
                        overrun   <= 1'b0;
                        state_q   <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

endmodule
